// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 encodings, LSU transfer sizes and the LSU master FSM state type.
package axi_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, RESP} lsu_state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_H && addr_lo[0]) || (size == SZ_W && addr_lo != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane placement for stores and lane extraction/extension for loads.
module lsu_lane_align
    import axi_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_sh,
    output logic [3:0]  wstrb,
    output logic [31:0] ext_data
);
    logic [31:0] rsh;

    always_comb begin
        wdata_sh = wdata << {addr_lo, 3'b000};
        wstrb    = (size == SZ_B ? 4'b0001 : size == SZ_H ? 4'b0011 : 4'b1111) << addr_lo;
        rsh      = rdata >> {addr_lo, 3'b000};
        ext_data = size == SZ_B ? {{24{~uns & rsh[7]}}, rsh[7:0]} :
                   size == SZ_H ? {{16{~uns & rsh[15]}}, rsh[15:0]} : rsh;
    end
endmodule

// File: rtl/lsu_axi_master.sv
// lsu_axi_master: turns single LSU load/store requests into single-beat AXI4 transactions.
module lsu_axi_master
    import axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID       = 4'h1,
    parameter bit         MISALIGN_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        lsu_awvalid,
    output logic [31:0] lsu_awaddr,
    output logic [3:0]  lsu_awid,
    output logic [7:0]  lsu_awlen,
    output logic [2:0]  lsu_awsize,
    output logic [1:0]  lsu_awburst,
    input  logic        lsu_awready,
    output logic        lsu_wvalid,
    output logic [31:0] lsu_wdata,
    output logic [3:0]  lsu_wstrb,
    output logic        lsu_wlast,
    input  logic        lsu_wready,
    input  logic        lsu_bvalid,
    input  logic [1:0]  lsu_bresp,
    input  logic [3:0]  lsu_bid,
    output logic        lsu_bready,
    output logic        lsu_arvalid,
    output logic [31:0] lsu_araddr,
    output logic [3:0]  lsu_arid,
    output logic [7:0]  lsu_arlen,
    output logic [2:0]  lsu_arsize,
    output logic [1:0]  lsu_arburst,
    input  logic        lsu_arready,
    input  logic        lsu_rvalid,
    input  logic [1:0]  lsu_rresp,
    input  logic [31:0] lsu_rdata,
    input  logic        lsu_rlast,
    input  logic [3:0]  lsu_rid,
    output logic        lsu_rready
);
    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d, err_q, err_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [31:0] wdata_sh, ext_data;
    logic [3:0]  wstrb;
    logic        unused_ids;

    assign unused_ids = ^{lsu_bid, lsu_rid};

    lsu_lane_align u_align (
        .addr_lo (addr_q[1:0]),
        .size    (size_q),
        .uns     (uns_q),
        .wdata   (wdata_q),
        .rdata   (lsu_rdata),
        .wdata_sh(wdata_sh),
        .wstrb   (wstrb),
        .ext_data(ext_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        lsu_arvalid = 1'b0;
        lsu_rready  = 1'b0;
        lsu_awvalid = 1'b0;
        lsu_wvalid  = 1'b0;
        lsu_bready  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (MISALIGN_ERR && misaligned(req_size, req_addr[1:0])) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = req_wen ? WREQ : RADDR;
                    end
                end
            end
            RADDR: begin
                lsu_arvalid = 1'b1;
                state_d     = lsu_arready ? RDATA : RADDR;
            end
            RDATA: begin
                lsu_rready = 1'b1;
                if (lsu_rvalid) begin
                    err_d   = (lsu_rresp != RESP_OKAY) || !lsu_rlast;
                    rdata_d = err_d ? '0 : ext_data;
                    state_d = RESP;
                end
            end
            WREQ: begin
                // each channel finishes independently; leave only when both have handshaken
                lsu_awvalid = !aw_done_q;
                lsu_wvalid  = !w_done_q;
                aw_done_d   = aw_done_q | lsu_awready;
                w_done_d    = w_done_q | lsu_wready;
                if (aw_done_d && w_done_d) begin
                    state_d   = WRESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WRESP: begin
                lsu_bready = 1'b1;
                if (lsu_bvalid) begin
                    err_d   = lsu_bresp != RESP_OKAY;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = resp_ready ? IDLE : RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // payload is zeroed whenever its channel is not presenting a request
    always_comb begin
        lsu_araddr  = lsu_arvalid ? addr_q : '0;
        lsu_arid    = lsu_arvalid ? AXI_ID : '0;
        lsu_arlen   = '0;
        lsu_arsize  = lsu_arvalid ? {1'b0, size_q} : '0;
        lsu_arburst = lsu_arvalid ? BURST_INCR : '0;
        lsu_awaddr  = lsu_awvalid ? addr_q : '0;
        lsu_awid    = lsu_awvalid ? AXI_ID : '0;
        lsu_awlen   = '0;
        lsu_awsize  = lsu_awvalid ? {1'b0, size_q} : '0;
        lsu_awburst = lsu_awvalid ? BURST_INCR : '0;
        lsu_wdata   = lsu_wvalid ? wdata_sh : '0;
        lsu_wstrb   = lsu_wvalid ? wstrb : '0;
        lsu_wlast   = lsu_wvalid;
        resp_rdata  = rdata_q;
        resp_err    = err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- Converts single load/store requests from the LSU pipeline stage into AXI4 single-beat transactions on the lsu_* master port.
- The lsu_* port feeds the IFU/LSU bus crossbar, which arbitrates it against the IFU onto io_master.
- Performs byte-lane alignment: wdata shift and wstrb generation on stores, lane extraction with sign/zero extension on loads.
- Returns one response per request to the LSU.

Parameters:
- AXI_ID, 4'h1: constant value driven on lsu_awid and lsu_arid.
- MISALIGN_ERR, 1: 1 = misaligned request completes with an error and no bus access; 0 = address passed through unmodified.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  LSU request valid.
- req_ready  output  1  block idle; request accepted on valid&ready.
- req_wen  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, LSB-aligned.
- req_size  input  2  00 byte, 01 half, 10 word.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- resp_valid  output  1  response valid; held until resp_ready.
- resp_ready  input  1  LSU accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  bus error (RRESP/BRESP != 0, or rlast=0) or misaligned access.
- lsu_awvalid/awaddr/awid/awlen/awsize/awburst  output  1/32/4/8/3/2  AW channel.
- lsu_awready  input  1  AW ready (crossbar-gated).
- lsu_wvalid/wdata/wstrb/wlast  output  1/32/4/1  W channel.
- lsu_wready  input  1  W ready.
- lsu_bvalid/bresp/bid  input  1/2/4  B channel; bid ignored.
- lsu_bready  output  1  B ready.
- lsu_arvalid/araddr/arid/arlen/arsize/arburst  output  1/32/4/8/3/2  AR channel.
- lsu_arready  input  1  AR ready.
- lsu_rvalid/rresp/rdata/rlast/rid  input  1/2/32/1/4  R channel; rid ignored.
- lsu_rready  output  1  R ready.

Behaviour:
- Reset: state IDLE, req_ready=1, and every other output 0 (all valids, readys, resp_rdata, resp_err, payload registers). Reset mid-transaction abandons the transaction; the slave is reset by the same signal.
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, RESP.
- IDLE: req_ready=1. On req_valid, latch addr, wdata, size, unsigned and wen.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) and MISALIGN_ERR=1 -> RESP with resp_err=1.
  - Otherwise wen -> WREQ; !wen -> RADDR.
- RADDR: arvalid=1, araddr=latched addr, arlen=0, arsize={1'b0,size}, arburst=2'b01, arid=AXI_ID. Payload stays stable until arready; the crossbar may hold arready=0 indefinitely. On arready -> RDATA.
- RDATA: rready=1. On rvalid, shift rdata right by addr[1:0]*8, then extend from size (sign or zero per req_unsigned).
  - resp_err = (rresp!=0) | !rlast; on error, rdata forced to 0.
  - Next state RESP.
- WREQ: awvalid and wvalid asserted together.
  - wdata = wdata << (addr[1:0]*8); wstrb = {0001, 0011, 1111}[size] << addr[1:0]; wlast=1.
  - Separate aw_done/w_done flags. Each valid drops the cycle after its own handshake. The two handshakes may complete in either order or in the same cycle.
  - When both are done -> WRESP; the flags clear.
- WRESP: bready=1. On bvalid, resp_err = (bresp!=0) -> RESP.
- RESP: resp_valid=1, outputs held. On resp_ready -> IDLE; resp_valid drops the next cycle. A new request can be accepted the cycle after RESP exits; there is no overlap.
- Latency with zero-wait slave and resp_ready=1:
  - Load accepted at cycle T: arvalid at T+1, rready at T+2, resp_valid at T+3.
  - Store accepted at T: aw/w at T+1, bready at T+2, resp_valid at T+3.
- At most one outstanding AXI transaction. req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package axi_pkg holds:
  - size encodings (SZ_B/SZ_H/SZ_W);
  - BURST_INCR=2'b01;
  - RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - the FSM state enum.
- One combinational sub-module, lsu_lane_align, handles both directions:
  - store path: (addr[1:0], size, wdata) -> (wdata_shifted, wstrb);
  - load path: (addr[1:0], size, unsigned, rdata) -> ext_data.

Test Plan:
- Load word 0x8000_0004, slave returns 0xDEADBEEF with OKAY, zero wait -> arvalid at T+1, resp_valid at T+3, resp_rdata=0xDEADBEEF, resp_err=0.
- Load byte signed at 0x8000_0003, rdata=0x80AABBCC -> resp_rdata=0xFFFFFF80; the same load with req_unsigned=1 -> 0x00000080.
- Store half 0x1234 at 0x8000_0002 -> wdata=0x12340000, wstrb=4'b1100, wlast=1. wready asserted 2 cycles after awready -> exactly one handshake per channel, then bready, resp_err=0.
- lsu_arready held 0 for 5 cycles (crossbar granting IFU) -> arvalid and araddr stable throughout; completes after arready rises.
- Load word at 0x8000_0001 -> no arvalid ever asserted; resp_valid with resp_err=1, resp_rdata=0. A store receiving bresp=2'b10 -> resp_err=1.
- reset asserted while in RDATA -> next cycle all valids/readys 0, req_ready=1; a fresh load then completes normally.
